// File: rtl/alu_acc_seq.sv
// Sequential 8-bit add/subtract accumulator driving an external ripple adder.
// Define ALU_OVERFLOW_FLAG_EN to build the registered signed-overflow flag.
module alu_acc_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_s,
  input  logic       add_cout,
  output logic [7:0] acc,
  output logic       busy,
  output logic       done,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpAdc = 2'b01;
  localparam logic [1:0] OpSub = 2'b10;
  localparam logic [1:0] OpSbc = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [1:0] op_q, op_d;
  logic [7:0] acc_q, acc_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_n_q, flag_n_d;
  logic       accept;
  logic       commit;

  assign accept = (state_q == StIdle) && start;
  assign commit = (state_q == StExec);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Subtraction is a + ~b + cin, so the carry out reads as "no borrow".
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (state_q == StExec) begin
      add_a = opa_q;
      add_b = op_q[1] ? ~opb_q : opb_q;
      unique case (op_q)
        OpAdd:   add_cin = 1'b0;
        OpSub:   add_cin = 1'b1;
        OpAdc,
        OpSbc:   add_cin = flag_c_q;
        default: add_cin = 1'b0;
      endcase
    end
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (accept) begin
      opa_d = opa;
      opb_d = opb;
      op_d  = op;
    end
    if (commit) begin
      acc_d    = add_s;
      flag_c_d = add_cout;
      flag_z_d = (add_s == 8'h00);
      flag_n_d = add_s[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      op_q     <= 2'b00;
      acc_q    <= 8'h00;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic flag_v_q, flag_v_d;

  always_comb begin
    flag_v_d = flag_v_q;
    if (commit) begin
      flag_v_d = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_v_q <= 1'b0;
    end else begin
      flag_v_q <= flag_v_d;
    end
  end

  assign flag_v = flag_v_q;
`else
  assign flag_v = 1'b0;
`endif

  assign acc    = acc_q;
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);

endmodule

// File: doc/alu_acc_seq.md
ALU_ACC_SEQ -- requirements
Module: alu_acc_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a new operation.
REQ-004 SHALL have port: op  input  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
REQ-005 SHALL have ports: opa, opb  input  8  operands, sampled only on an accepted start.
REQ-006 SHALL have ports: add_a, add_b  output  8  and add_cin  output  1  drive to the external 8-bit ripple adder.
REQ-007 SHALL have ports: add_s  input  8  and add_cout  input  1  combinational sum/carry returned from the adder.
REQ-008 SHALL have ports: acc  output  8  result register; busy  output  1; done  output  1.
REQ-009 SHALL have ports: flag_c, flag_z, flag_n, flag_v  output  1 each  status flags.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE, one cycle per state except IDLE.
REQ-011 SHALL accept start only in IDLE; accept latches opa, opb and op, next state EXEC.
REQ-012 SHALL ignore start in EXEC and DONE, with no queuing.
REQ-013 SHALL, in EXEC only, drive add_a = opa_q, add_b = opb_q (ADD/ADC) or ~opb_q (SUB/SBC).
REQ-014 SHALL drive add_cin in EXEC as: ADD 0, SUB 1, ADC/SBC current flag_c.
REQ-015 SHALL drive add_a, add_b, add_cin to 0 outside EXEC.
REQ-016 SHALL, at the EXEC->DONE edge, load acc <= add_s and flag_c <= add_cout; for SUB/SBC, C=1 means no borrow.
REQ-017 SHALL, at the same edge, set flag_z = (add_s == 0) and flag_n = add_s[7].
REQ-018 SHALL, at the same edge, set flag_v = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]).
REQ-019 SHALL assert busy in EXEC and DONE, deassert it in IDLE.
REQ-020 SHALL assert done for exactly one cycle, in DONE; acc and flags are valid from that cycle onward.
REQ-021 SHALL have latency: start accepted at edge N -> done high in cycle after edge N+1; back-to-back throughput is one op per 3 cycles.
REQ-022 SHALL hold acc and flags unchanged outside the EXEC->DONE edge.

Reset
REQ-023 SHALL, when rst_n is low at a rising edge, force state IDLE, acc=0x00, all flags 0, busy=0, done=0, and latched operands 0.
REQ-024 SHALL abort any in-flight operation on reset, with no done pulse and no acc/flag update.
REQ-025 SHALL ignore start in the same cycle as reset.

Configuration
REQ-026 SHALL, with ALU_OVERFLOW_FLAG_EN defined, compute and register flag_v per REQ-018.
REQ-027 SHALL, without ALU_OVERFLOW_FLAG_EN, tie flag_v to constant 0 with no flag_v register; all other behaviour is identical.

Verification
REQ-028 SHALL cover ADD 0x7F+0x01 -> acc 0x80, N=1, V=1 (0 if macro off), C=0, Z=0, done 2 cycles after start.
REQ-029 SHALL cover ADD 0xFF+0x01 then ADC 0x00+0x00 -> first acc 0x00, Z=1, C=1; second acc 0x01, C=0, Z=0.
REQ-030 SHALL cover SUB 0x05-0x05 -> acc 0x00, Z=1, C=1; then SBC 0x10-0x01 with C forced 0 by a prior SUB 0x00-0x01 (acc 0xFF, C=0, N=1) -> acc 0x0E, C=1.
REQ-031 SHALL cover start pulsed every cycle for 6 cycles -> exactly 2 operations complete, done pulses 3 cycles apart.
REQ-032 SHALL cover rst_n low during EXEC -> next cycle acc 0x00, flags 0, busy 0, no done pulse.
REQ-033 SHALL check add_a, add_b and add_cin are 0 in every non-EXEC cycle throughout all scenarios.
